// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM state and reset-cause encoding.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        StAssert  = 2'd0,
        StRelease = 2'd1,
        StRun     = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CausePor = 2'd0,
        CauseBtn = 2'd1,
        CausePll = 2'd2,
        CauseSw  = 2'd3
    } rst_cause_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_debounce.sv
// Level debouncer: the output follows the input only after the input has
// differed from it for DebounceCycles consecutive cycles.
module rst_debounce #(
    parameter int unsigned DebounceCycles = 1000
) (
    input  logic clk_sys_i,
    input  logic rst_sys_ni,
    input  logic level_i,
    output logic level_o
);

    localparam int unsigned CntW = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;
    logic            r_level;
    logic            w_level_d;

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_comb begin
        w_cnt_d   = '0;
        w_level_d = r_level;
        if (level_i != r_level) begin
            if (r_cnt == CntLast) begin
                w_level_d = level_i;
            end else begin
                w_cnt_d = r_cnt + CntW'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_d;
            r_level <= w_level_d;
        end
    end

    assign level_o = r_level;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: asserts all reset outputs at once on any trigger, holds them
// for a minimum time after the last trigger, then releases them one by one.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int unsigned NumRst         = 3,
    parameter int unsigned DebounceCycles = 1000,
    parameter int unsigned HoldCycles     = 16,
    parameter int unsigned StageGap       = 8
) (
    input  logic              clk_sys_i,
    input  logic              rst_sys_ni,
    input  logic              pll_locked_i,
    input  logic              rst_btn_i,
    input  logic              sw_rst_req_i,
    output logic [NumRst-1:0] rst_no,
    output logic [1:0]        rst_cause_o,
    output logic              busy_o
);

    // One counter serves both the hold time and the inter-stage gap.
    localparam int unsigned CntMax = max_u(HoldCycles, StageGap);
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(StageGap - 1);

    logic r_lock_meta;
    logic r_lock_sync;
    logic r_btn_meta;
    logic r_btn_sync;
    logic w_btn_db;
    logic w_trigger;

    state_e          r_state;
    state_e          w_state_d;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;
    logic [NumRst-1:0] r_rst;
    logic [NumRst-1:0] w_rst_d;
    logic [NumRst-1:0] w_rst_first;
    logic [NumRst-1:0] w_rst_next;
    rst_cause_e      r_cause;
    rst_cause_e      w_cause_d;
    rst_cause_e      w_cause_new;
    logic            r_busy;
    logic            w_busy_d;

    // Two-flop synchronisers for the asynchronous lock and button inputs.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_btn_meta  <= 1'b0;
            r_btn_sync  <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked_i;
            r_lock_sync <= r_lock_meta;
            r_btn_meta  <= rst_btn_i;
            r_btn_sync  <= r_btn_meta;
        end
    end

    rst_debounce #(
        .DebounceCycles(DebounceCycles)
    ) u_debounce (
        .clk_sys_i (clk_sys_i),
        .rst_sys_ni(rst_sys_ni),
        .level_i   (r_btn_sync),
        .level_o   (w_btn_db)
    );

    assign w_trigger = ~r_lock_sync | w_btn_db | sw_rst_req_i;

    // Released bits fill from bit 0 upwards; all-ones means fully released.
    assign w_rst_first = NumRst'(1);
    assign w_rst_next  = NumRst'({r_rst, 1'b1});

    // Cause priority when several sources fire together: pll > button > software.
    always_comb begin
        if (!r_lock_sync) begin
            w_cause_new = CausePll;
        end else if (w_btn_db) begin
            w_cause_new = CauseBtn;
        end else begin
            w_cause_new = CauseSw;
        end
    end

    // Sequencer next-state: immediate assertion, staged release.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_rst_d   = r_rst;
        w_cause_d = r_cause;
        case (r_state)
            StAssert: begin
                w_rst_d = '0;
                if (w_trigger) begin
                    w_cnt_d = '0;
                end else if (r_cnt == HoldLast) begin
                    w_rst_d   = w_rst_first;
                    w_cnt_d   = '0;
                    w_state_d = (&w_rst_first) ? StRun : StRelease;
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                end
            end
            StRelease: begin
                if (w_trigger) begin
                    w_state_d = StAssert;
                    w_rst_d   = '0;
                    w_cnt_d   = '0;
                    w_cause_d = w_cause_new;
                end else if (r_cnt == GapLast) begin
                    w_rst_d   = w_rst_next;
                    w_cnt_d   = '0;
                    w_state_d = (&w_rst_next) ? StRun : StRelease;
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                end
            end
            StRun: begin
                if (w_trigger) begin
                    w_state_d = StAssert;
                    w_rst_d   = '0;
                    w_cnt_d   = '0;
                    w_cause_d = w_cause_new;
                end
            end
            default: begin
                w_state_d = StAssert;
                w_rst_d   = '0;
                w_cnt_d   = '0;
            end
        endcase
        w_busy_d = ~&w_rst_d;
    end

    // Sequencer state and output registers; every output comes from a flop.
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            r_state <= StAssert;
            r_cnt   <= '0;
            r_rst   <= '0;
            r_cause <= CausePor;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_rst   <= w_rst_d;
            r_cause <= w_cause_d;
            r_busy  <= w_busy_d;
        end
    end

    assign rst_no      = r_rst;
    assign rst_cause_o = r_cause;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed testbench for rst_seq_ctrl: vector table for power-on, software reset
// and button debounce, plus hand-written lock-loss, coincident-cause and
// asynchronous-reset sequences.
module tb_rst_seq_ctrl;

    localparam int unsigned NumRst         = 3;
    localparam int unsigned DebounceCycles = 4;
    localparam int unsigned HoldCycles     = 16;
    localparam int unsigned StageGap       = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       lock  = 1'b1;
    logic       btn   = 1'b0;
    logic       sw    = 1'b0;
    logic [2:0] rst_no;
    logic [1:0] cause;
    logic       busy;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int         cyc;
        logic       lock;
        logic       btn;
        logic       sw;
        logic [2:0] rst;
        logic       busy;
        logic [1:0] cause;
    } vec_t;

    vec_t pwr_v[$];
    vec_t run_v[$];

    always #5 clk = ~clk;

    rst_seq_ctrl #(
        .NumRst        (NumRst),
        .DebounceCycles(DebounceCycles),
        .HoldCycles    (HoldCycles),
        .StageGap      (StageGap)
    ) dut (
        .clk_sys_i   (clk),
        .rst_sys_ni  (rst_n),
        .pll_locked_i(lock),
        .rst_btn_i   (btn),
        .sw_rst_req_i(sw),
        .rst_no      (rst_no),
        .rst_cause_o (cause),
        .busy_o      (busy)
    );

    function automatic vec_t mk(input int cyc, input logic l, input logic b, input logic s,
                                input logic [2:0] r, input logic bz, input logic [1:0] c);
        vec_t v;
        v.cyc   = cyc;
        v.lock  = l;
        v.btn   = b;
        v.sw    = s;
        v.rst   = r;
        v.busy  = bz;
        v.cause = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [2:0] e_rst, input logic e_busy,
                             input logic [1:0] e_cause);
        check({name, "/rst_no"}, 8'(rst_no), 8'(e_rst));
        check({name, "/busy"}, 8'(busy), 8'(e_busy));
        check({name, "/cause"}, 8'(cause), 8'(e_cause));
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply(input string tag, input int idx, input vec_t v);
        lock = v.lock;
        btn  = v.btn;
        sw   = v.sw;
        tick(v.cyc);
        check_out($sformatf("%s[%0d]", tag, idx), v.rst, v.busy, v.cause);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on timing, counted from the edge after reset release.
        pwr_v.push_back(mk(1,  1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 2'd0)); // edge 1
        pwr_v.push_back(mk(16, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 2'd0)); // edge 17
        pwr_v.push_back(mk(1,  1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 2'd0)); // edge 18
        pwr_v.push_back(mk(7,  1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 2'd0)); // edge 25
        pwr_v.push_back(mk(1,  1'b1, 1'b0, 1'b0, 3'b011, 1'b1, 2'd0)); // edge 26
        pwr_v.push_back(mk(7,  1'b1, 1'b0, 1'b0, 3'b011, 1'b1, 2'd0)); // edge 33
        pwr_v.push_back(mk(1,  1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 2'd0)); // edge 34

        // Software reset, then a short and a long button press.
        run_v.push_back(mk(5,  1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 2'd0)); // edge 39
        run_v.push_back(mk(1,  1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 2'd3)); // edge 40
        run_v.push_back(mk(15, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 2'd3)); // edge 55
        run_v.push_back(mk(1,  1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 2'd3)); // edge 56
        run_v.push_back(mk(8,  1'b1, 1'b0, 1'b0, 3'b011, 1'b1, 2'd3)); // edge 64
        run_v.push_back(mk(8,  1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 2'd3)); // edge 72
        run_v.push_back(mk(3,  1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 2'd3)); // 3-cycle press
        run_v.push_back(mk(10, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 2'd3)); // edge 85
        run_v.push_back(mk(6,  1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 2'd3)); // debounced at 91
        run_v.push_back(mk(1,  1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 2'd1)); // edge 92
        run_v.push_back(mk(3,  1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 2'd1)); // edge 95
        run_v.push_back(mk(21, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 2'd1)); // edge 116
        run_v.push_back(mk(1,  1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 2'd1)); // debounced fell at 101

        #2 rst_n = 1'b0;
        tick(3);
        check_out("reset_state", 3'b000, 1'b1, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < pwr_v.size(); i++) apply("power_on", i, pwr_v[i]);
        for (int i = 0; i < run_v.size(); i++) apply("run", i, run_v[i]);

        // Lock loss while two stages are released.
        tick(8);
        check_out("lock_pre", 3'b011, 1'b1, 2'd1);
        lock = 1'b0;
        tick(2);
        check_out("lock_sync_delay", 3'b011, 1'b1, 2'd1);
        tick(1);
        check_out("lock_assert", 3'b000, 1'b1, 2'd2);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check($sformatf("lock_low_hold[%0d]", i), 8'(rst_no), 8'd0);
        end
        lock = 1'b1;
        tick(17);
        check_out("lock_hold_end", 3'b000, 1'b1, 2'd2);
        tick(1);
        check_out("lock_release", 3'b001, 1'b1, 2'd2);
        tick(16);
        check_out("lock_run", 3'b111, 1'b0, 2'd2);

        // Move the latched cause away from pll before the coincidence test.
        sw = 1'b1;
        tick(1);
        check_out("sw_again", 3'b000, 1'b1, 2'd3);
        sw = 1'b0;
        tick(32);
        check_out("sw_again_run", 3'b111, 1'b0, 2'd3);

        // Software pulse on the same edge the synchronised lock drops.
        lock = 1'b0;
        tick(2);
        check_out("coincide_pre", 3'b111, 1'b0, 2'd3);
        sw = 1'b1;
        tick(1);
        check_out("coincide", 3'b000, 1'b1, 2'd2);
        sw   = 1'b0;
        lock = 1'b1;
        tick(26);
        check_out("coincide_recover", 3'b011, 1'b1, 2'd2);

        // Asynchronous reset between edges, mid-release.
        #3 rst_n = 1'b0;
        #1;
        check_out("async_reset", 3'b000, 1'b1, 2'd0);
        tick(2);
        check_out("async_reset_held", 3'b000, 1'b1, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < pwr_v.size(); i++) apply("power_on2", i, pwr_v[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have parameter NumRst, default 3, meaning the number of reset outputs released in sequence (range 1..8).
REQ-002 SHALL have parameter DebounceCycles, default 1000, meaning the cycles a synchronised button level must be stable before it is accepted (>=1).
REQ-003 SHALL have parameter HoldCycles, default 16, meaning the minimum all-asserted cycles after the last trigger (>=1).
REQ-004 SHALL have parameter StageGap, default 8, meaning the cycles between consecutive output releases (>=1).
REQ-005 SHALL have port clk_sys_i, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_sys_ni, input, 1 bit: the reset, asynchronous and active-low.
REQ-007 SHALL have port pll_locked_i, input, 1 bit: PLL lock, asynchronous.
REQ-008 SHALL have port rst_btn_i, input, 1 bit: reset button, active-high, asynchronous, may bounce.
REQ-009 SHALL have port sw_rst_req_i, input, 1 bit: software reset request, synchronous to clk_sys_i.
REQ-010 SHALL have port rst_no, output, NumRst bits: active-low resets; bit 0 is released first.
REQ-011 SHALL have port rst_cause_o, output, 2 bits: latched cause of the last reset (0 = por, 1 = button, 2 = pll loss, 3 = software).
REQ-012 SHALL have port busy_o, output, 1 bit: high whenever any rst_no bit is asserted.

Function
REQ-013 SHALL pass pll_locked_i and rst_btn_i through 2-flop synchronisers, giving 2 cycles of latency.
REQ-014 SHALL change the debounced button level only after the synchronised level has differed from it for DebounceCycles consecutive cycles; any glitch restarts the count.
REQ-015 SHALL define trigger as (synchronised lock == 0) OR (debounced button == 1) OR (sw_rst_req_i == 1).
REQ-016 SHALL implement three states: ASSERT, RELEASE and RUN.
REQ-017 In ASSERT, SHALL hold all rst_no = 0 and clear the hold counter while trigger is high, otherwise increment it.
REQ-018 In ASSERT, SHALL move to RELEASE, set rst_no[0] = 1 and clear the counter on the edge where the counter == HoldCycles-1 and trigger is low.
REQ-019 In RELEASE, SHALL set the next rst_no bit to 1 on each edge where the gap counter == StageGap-1, then clear the counter.
REQ-020 SHALL enter RUN on the same edge that rst_no[NumRst-1] is released; when NumRst = 1, SHALL go directly from ASSERT to RUN.
REQ-021 On trigger in RELEASE or RUN, SHALL go to ASSERT, drive all rst_no = 0 on the next edge and clear the counter.
REQ-022 SHALL assert outputs with no sequencing; only release is staged.
REQ-023 SHALL latch rst_cause_o on every trigger edge seen outside ASSERT, using priority pll > button > software when causes coincide.
REQ-024 SHALL ignore triggers for rst_cause_o while already in ASSERT.
REQ-025 SHALL drive every output directly from a flop.
REQ-026 SHALL ignore sw_rst_req_i pulses shorter than one cycle; a one-cycle pulse is sufficient to trigger.

Reset
REQ-027 SHALL, while rst_sys_ni = 0: state = ASSERT, rst_no = all 0, rst_cause_o = 0, busy_o = 1, counters = 0, synchronisers = 0, debounced button = 0.
REQ-028 SHALL apply reset asynchronously on assertion, regardless of state or counters mid-operation.

Structure
REQ-029 SHALL place the state enum and the rst_cause_e encoding in shared package rst_seq_pkg.
REQ-030 SHALL implement the debouncer as sub-module rst_debounce, parameterised by DebounceCycles, with its counter width computed as $clog2(DebounceCycles+1).
REQ-031 SHALL size the shared hold/gap counter to the larger of HoldCycles and StageGap.

Verification (NumRst=3, HoldCycles=16, StageGap=8, DebounceCycles=4; edge n = nth rising edge after rst_sys_ni goes high)
REQ-032 SHALL check power-on: lock = 1 and button = 0 throughout -> rst_no = 001 at edge 18, 011 at edge 26, 111 at edge 34; busy_o falls at edge 34; rst_cause_o = 0.
REQ-033 SHALL check button debounce: in RUN, a button pulse of 3 cycles -> no reset; a pulse held for 10 cycles -> rst_no = 000 and rst_cause_o = 1, with release restarting 16 cycles after the debounced button falls.
REQ-034 SHALL check lock loss mid-RELEASE: lock drops while rst_no = 011 -> rst_no = 000 3 cycles later and rst_cause_o = 2; no release while lock is low.
REQ-035 SHALL check software reset: a one-cycle sw_rst_req_i in RUN -> rst_no = 000 next edge, rst_cause_o = 3, rst_no = 001 16 edges later.
REQ-036 SHALL check simultaneous causes: sw_rst_req_i pulse on the same edge as synchronised lock loss -> rst_cause_o = 2.
REQ-037 SHALL check asynchronous reset mid-sequence: rst_sys_ni pulled low between clock edges -> rst_no = 000 and busy_o = 1 immediately, with the power-on timing repeated afterwards.
